// File: rtl/gate_preact_acc.sv
// -----------------------------------------------------------------------------
// gate_preact_acc
//
// Builds one LSTM gate pre-activation per input vector. Weight x activation
// beats are multiplied at full precision, accumulated, offset by the bias, and
// then rounded and saturated into the (1,5,12) format that tanh_in expects.
// The block has no stalls and no backpressure: one beat per cycle at most, and
// one 18-bit result word per vector.
//
// Ports
//   clk        single clock, everything on posedge
//   rst        synchronous active-high reset
//   in_valid   beat qualifier for x_in / w_in
//   in_last    final beat of the vector (ignored when in_valid is low)
//   x_in       signed activation, (1,5,12)
//   w_in       signed weight, (1,0,17)
//   bias_in    signed bias, (1,5,12); only sampled on the in_last beat
//   out_valid  one-cycle pulse per completed vector
//   out_data   signed pre-activation, (1,5,12); holds between pulses
//   out_sat    1 = out_data was clipped; qualified by out_valid
//   len_err    sticky: some vector ran past MAX_LEN beats; cleared by rst only
//
// Pipeline (edge E samples the last beat, out_valid is high after E+4)
//   S0  input registers                       (E)
//   S1  36-bit product, (2,5,29)              (E+1)
//   S2  accumulator, ACC_W bits, 29 frac bits (E+2)
//   S3a bias add + round to 12 frac bits      (E+3)
//   S3b saturate and drive outputs            (E+4)
// -----------------------------------------------------------------------------
module gate_preact_acc #(
    parameter int ACC_W   = 48,
    parameter int MAX_LEN = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [17:0] x_in,
    input  logic [17:0] w_in,
    input  logic [17:0] bias_in,
    output logic        out_valid,
    output logic [17:0] out_data,
    output logic        out_sat,
    output logic        len_err
);

    // The beat counter saturates at MAX_LEN, so it only needs to reach that value.
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    // Width of the rounded sum once the 17 extra fractional bits are dropped.
    localparam int Q_W   = ACC_W - 16;

    // ---------------------------------------------------------------- S0
    logic             s0_valid_q, s0_valid_d;
    logic             s0_last_q,  s0_last_d;
    logic [17:0]      s0_x_q,     s0_x_d;
    logic [17:0]      s0_w_q,     s0_w_d;
    logic [17:0]      s0_bias_q,  s0_bias_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             len_err_q,  len_err_d;

    // ---------------------------------------------------------------- S1
    logic             s1_valid_q, s1_valid_d;
    logic             s1_last_q,  s1_last_d;
    logic [35:0]      s1_prod_q,  s1_prod_d;
    logic [17:0]      s1_bias_q,  s1_bias_d;

    // ---------------------------------------------------------------- S2
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic             fresh_q,    fresh_d;
    logic             s2_done_q,  s2_done_d;
    logic [17:0]      s2_bias_q,  s2_bias_d;

    // ---------------------------------------------------------------- S3a
    logic             s3_valid_q, s3_valid_d;
    logic [Q_W-1:0]   s3_q_q,     s3_q_d;

    // ---------------------------------------------------------------- S3b
    logic             out_valid_q, out_valid_d;
    logic [17:0]      out_data_q,  out_data_d;
    logic             out_sat_q,   out_sat_d;

    // ---------------------------------------------------------------- S0 logic
    always_comb begin
        s0_valid_d = in_valid;
        // in_last only means something on a valid beat.
        s0_last_d  = in_valid & in_last;
        s0_x_d     = s0_x_q;
        s0_w_d     = s0_w_q;
        s0_bias_d  = s0_bias_q;
        cnt_d      = cnt_q;
        len_err_d  = len_err_q;

        if (in_valid) begin
            s0_x_d    = x_in;
            s0_w_d    = w_in;
            s0_bias_d = bias_in;
            // cnt_q is the number of beats already seen in this vector, so a
            // beat arriving with cnt_q == MAX_LEN is beat number MAX_LEN+1.
            if (cnt_q == CNT_W'(MAX_LEN)) begin
                len_err_d = 1'b1;
            end
            if (in_last) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_W'(MAX_LEN)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------- S1 logic
    // Both operands are sign-extended to 36 bits; the low 36 bits of the
    // unsigned product are then the exact two's-complement product, which
    // always fits since |x*w| <= 2^34.
    logic [35:0] x_ext, w_ext;

    always_comb begin
        x_ext      = {{18{s0_x_q[17]}}, s0_x_q};
        w_ext      = {{18{s0_w_q[17]}}, s0_w_q};
        s1_valid_d = s0_valid_q;
        s1_last_d  = s0_last_q;
        s1_prod_d  = s1_prod_q;
        s1_bias_d  = s1_bias_q;
        if (s0_valid_q) begin
            s1_prod_d = x_ext * w_ext;
            s1_bias_d = s0_bias_q;
        end
    end

    // ---------------------------------------------------------------- S2 logic
    // fresh marks that the next valid beat opens a new vector, so a first beat
    // right behind a last beat restarts from zero without needing a bubble.
    // The completed sum stays in acc_q for exactly one cycle, which is when
    // S3a picks it up.
    logic [ACC_W-1:0] acc_base;

    always_comb begin
        acc_base  = fresh_q ? '0 : acc_q;
        acc_d     = acc_q;
        fresh_d   = fresh_q;
        s2_done_d = s1_valid_q & s1_last_q;
        s2_bias_d = s2_bias_q;
        if (s1_valid_q) begin
            // Wraps modulo 2^ACC_W on overlong vectors; len_err flags that case.
            acc_d   = acc_base + {{(ACC_W-36){s1_prod_q[35]}}, s1_prod_q};
            fresh_d = s1_last_q;
            if (s1_last_q) begin
                s2_bias_d = s1_bias_q;
            end
        end
    end

    // ---------------------------------------------------------------- S3a logic
    // Target: q = (acc + (bias << 17) + 2^16) >>> 17.
    // The bias term has no bits below 17, so it can be added after the shift,
    // and adding 2^16 before the shift is the same as adding acc[16] after it.
    // This keeps the adder at ACC_W-16 bits with an identical result.
    logic [Q_W-1:0] acc_hi;
    logic [Q_W-1:0] bias_ext;
    logic [Q_W-1:0] round_bit;

    always_comb begin
        acc_hi     = {acc_q[ACC_W-1], acc_q[ACC_W-1:17]};
        bias_ext   = {{(Q_W-18){s2_bias_q[17]}}, s2_bias_q};
        round_bit  = {{(Q_W-1){1'b0}}, acc_q[16]};
        s3_valid_d = s2_done_q;
        s3_q_d     = s3_q_q;
        if (s2_done_q) begin
            s3_q_d = acc_hi + bias_ext + round_bit;
        end
    end

    // ---------------------------------------------------------------- S3b logic
    // The rounded value fits in 18 bits exactly when every bit from 17 up is a
    // copy of the sign; otherwise the sign picks which rail to clip to.
    logic q_fits;

    always_comb begin
        q_fits      = (&s3_q_q[Q_W-1:17]) | ~(|s3_q_q[Q_W-1:17]);
        out_valid_d = s3_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (s3_valid_q) begin
            if (q_fits) begin
                out_data_d = s3_q_q[17:0];
                out_sat_d  = 1'b0;
            end else if (s3_q_q[Q_W-1]) begin
                out_data_d = 18'h20000;
                out_sat_d  = 1'b1;
            end else begin
                out_data_d = 18'h1FFFF;
                out_sat_d  = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q  <= 1'b0;
            s0_last_q   <= 1'b0;
            s0_x_q      <= '0;
            s0_w_q      <= '0;
            s0_bias_q   <= '0;
            cnt_q       <= '0;
            len_err_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_prod_q   <= '0;
            s1_bias_q   <= '0;
            acc_q       <= '0;
            fresh_q     <= 1'b1;
            s2_done_q   <= 1'b0;
            s2_bias_q   <= '0;
            s3_valid_q  <= 1'b0;
            s3_q_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            s0_valid_q  <= s0_valid_d;
            s0_last_q   <= s0_last_d;
            s0_x_q      <= s0_x_d;
            s0_w_q      <= s0_w_d;
            s0_bias_q   <= s0_bias_d;
            cnt_q       <= cnt_d;
            len_err_q   <= len_err_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_prod_q   <= s1_prod_d;
            s1_bias_q   <= s1_bias_d;
            acc_q       <= acc_d;
            fresh_q     <= fresh_d;
            s2_done_q   <= s2_done_d;
            s2_bias_q   <= s2_bias_d;
            s3_valid_q  <= s3_valid_d;
            s3_q_q      <= s3_q_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_gate_preact_acc.sv
// -----------------------------------------------------------------------------
// tb_gate_preact_acc
//
// Directed bench for gate_preact_acc. Each vector sent pushes its expected
// result (from an independent 64-bit model) and the cycle it must appear on
// into a scoreboard; a negedge monitor pops and compares on every out_valid.
// -----------------------------------------------------------------------------
module tb_gate_preact_acc;

    localparam int MAX_LEN = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic [17:0] x_in;
    logic [17:0] w_in;
    logic [17:0] bias_in;
    logic        out_valid;
    logic [17:0] out_data;
    logic        out_sat;
    logic        len_err;

    gate_preact_acc #(.ACC_W(48), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .x_in      (x_in),
        .w_in      (w_in),
        .bias_in   (bias_in),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [17:0] data;
        logic        sat;
        int unsigned due;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   errors = 0;
    int   checks = 0;

    // Reference: exact integer arithmetic, round half up, clip to 18 bits.
    function automatic exp_t model(input longint acc, input int bias);
        exp_t   e;
        longint s;
        longint q;
        s = acc + (longint'(bias) * 131072) + 65536;
        q = s >>> 17;
        if (q > 131071) begin
            e.data = 18'h1FFFF;
            e.sat  = 1'b1;
        end else if (q < -131072) begin
            e.data = 18'h20000;
            e.sat  = 1'b1;
        end else begin
            e.data = q[17:0];
            e.sat  = 1'b0;
        end
        e.due = 0;
        return e;
    endfunction

    // Drives n beats of constant x/w; bias only matters on the last beat, so
    // other beats carry random bias. With gaps, an idle cycle (carrying a
    // stray in_last) follows every non-final beat.
    task automatic send_vec(input int n, input int x, input int w, input int bias, input bit gaps);
        longint acc;
        exp_t   e;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = (i == n - 1);
            x_in     = x[17:0];
            w_in     = w[17:0];
            bias_in  = (i == n - 1) ? bias[17:0] : 18'($urandom);
            acc      = acc + longint'(x) * longint'(w);
            if (i == n - 1) begin
                e     = model(acc, bias);
                e.due = cyc + 5;
                sb.push_back(e);
            end else if (gaps) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b1;
                x_in     = 18'($urandom);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Scoreboard monitor, sampled on the negedge away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL spurious_valid: out_valid=1 at cycle %0d, expected no pending result", cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                last_exp = e;
                checks++;
                assert (out_data === e.data) else begin
                    errors++;
                    $error("FAIL out_data: observed=%h expected=%h", out_data, e.data);
                end
                checks++;
                assert (out_sat === e.sat) else begin
                    errors++;
                    $error("FAIL out_sat: observed=%b expected=%b", out_sat, e.sat);
                end
                checks++;
                assert (cyc === e.due) else begin
                    errors++;
                    $error("FAIL latency: observed cycle=%0d expected cycle=%0d", cyc, e.due);
                end
                $display("vector result data=%h sat=%b cycle=%0d", out_data, out_sat, cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        x_in     = '0;
        w_in     = '0;
        bias_in  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        checks++;
        assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_out_valid: observed=%b expected=0", out_valid); end
        checks++;
        assert (out_data === 18'h0) else begin errors++; $error("FAIL rst_out_data: observed=%h expected=0", out_data); end
        checks++;
        assert (out_sat === 1'b0) else begin errors++; $error("FAIL rst_out_sat: observed=%b expected=0", out_sat); end
        checks++;
        assert (len_err === 1'b0) else begin errors++; $error("FAIL rst_len_err: observed=%b expected=0", len_err); end
        rst = 1'b0;
        idle(2);

        // Single beats: basic product, rounding path, bias only, bias at the rail
        send_vec(1, 4096, 65536, 0, 1'b0);
        idle(6);
        send_vec(1, -4096, 131071, 0, 1'b0);
        idle(6);
        send_vec(1, 0, 0, 1000, 1'b0);
        send_vec(1, 0, 0, -131072, 1'b0);
        idle(6);

        // Saturation both ways (second one with gaps and stray in_last)
        send_vec(8, 131071, 131071, 0, 1'b0);
        idle(6);
        send_vec(8, -131072, 131071, 0, 1'b1);
        idle(6);

        // Back-to-back vectors A and B, then a gapped vector with a bias
        send_vec(3, 4096, 32768, 0, 1'b0);
        send_vec(2, 8192, 32768, 0, 1'b0);
        send_vec(4, 1000, -3000, 77, 1'b1);
        idle(10);

        // Outputs hold between pulses
        checks++;
        assert (out_data === last_exp.data) else begin
            errors++;
            $error("FAIL hold_data: observed=%h expected=%h", out_data, last_exp.data);
        end

        // Reset in the middle of a vector: partial sum and in-flight beats vanish
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = 1'b0;
            x_in     = 18'd4096;
            w_in     = 18'd32768;
            bias_in  = 18'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_vec(1, 4096, 131071, 0, 1'b0);
        idle(8);
        checks++;
        assert (len_err === 1'b0) else begin errors++; $error("FAIL len_err_after_rst_test: observed=%b expected=0", len_err); end

        // Exactly MAX_LEN beats is legal
        send_vec(MAX_LEN, 100, 2000, 5, 1'b0);
        idle(6);
        checks++;
        assert (len_err === 1'b0) else begin errors++; $error("FAIL len_err_max_len: observed=%b expected=0", len_err); end

        // MAX_LEN+1 beats sets the sticky error
        send_vec(MAX_LEN + 1, 100, 2000, 0, 1'b0);
        idle(6);
        checks++;
        assert (len_err === 1'b1) else begin errors++; $error("FAIL len_err_set: observed=%b expected=1", len_err); end
        send_vec(2, 4096, 65536, 0, 1'b0);
        idle(20);
        checks++;
        assert (len_err === 1'b1) else begin errors++; $error("FAIL len_err_sticky: observed=%b expected=1", len_err); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        assert (len_err === 1'b0) else begin errors++; $error("FAIL len_err_clear: observed=%b expected=0", len_err); end

        // Every pushed result must have come out
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain: observed pending=%0d expected pending=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
